// File: rtl/clint_pkg.sv
// Shared constants and types for the multi-hart core-local interruptor.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CTRL_OFS      = 16'hBFF0;
  localparam logic [15:0] PRESC_OFS     = 16'hBFF4;
  localparam logic [15:0] MTIMEL_OFS    = 16'hBFF8;
  localparam logic [15:0] MTIMEH_OFS    = 16'hBFFC;

  localparam int CLINT_MTIME_WIDTH = 64;

  // Field order puts en at bit 0 and src at bit 1 of CTRL.
  typedef struct packed {
    logic src;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/apb4_mclint_if.sv
// APB4 slave-port bundle for the CLINT (16-bit byte address, 32-bit data).
interface apb4_mclint_if;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/clint_tick_gen.sv
// Tick generator: rtc synchronizer, rising-edge detect, source select and
// prescaler. inc_o pulses once per PRESC+1 enabled raw ticks.
module clint_tick_gen #(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rtc_clk_i,
  input  logic                 en_i,
  input  logic                 src_i,
  input  logic [PSC_WIDTH-1:0] presc_i,
  input  logic                 presc_wr_i,
  output logic                 inc_o
);
  logic [1:0]           sync_q;
  logic                 rtc_prev_q;
  logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
  logic                 rtc_tick, tick_en;

  assign rtc_tick = sync_q[1] & ~rtc_prev_q;
  assign tick_en  = (src_i | rtc_tick) & en_i;
  assign inc_o    = tick_en && (psc_cnt_q == presc_i);

  // Prescale counter next state; a PRESC write restarts the count.
  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (tick_en) psc_cnt_d = inc_o ? '0 : psc_cnt_q + PSC_WIDTH'(1);
    if (presc_wr_i) psc_cnt_d = '0;
  end

  // Synchronizer, edge-detect history and prescale counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      rtc_prev_q <= 1'b0;
      psc_cnt_q  <= '0;
    end else begin
      sync_q     <= {sync_q[0], rtc_clk_i};
      rtc_prev_q <= sync_q[1];
      psc_cnt_q  <= psc_cnt_d;
    end
  end
endmodule

// File: rtl/apb4_mclint.sv
// Multi-hart CLINT on APB4: shared mtime, per-hart msip/mtimecmp, CTRL and
// PRESC registers, and combinational timer/software interrupt outputs.
module apb4_mclint
  import clint_pkg::*;
#(
  parameter int NUM_HART  = 4,
  parameter int PSC_WIDTH = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  apb4_mclint_if.slave        apb,
  input  logic                rtc_clk_i,
  output logic [NUM_HART-1:0] tmr_irq_o,
  output logic [NUM_HART-1:0] sfr_irq_o
);
  localparam int          MW       = CLINT_MTIME_WIDTH;
  localparam logic [11:0] HART_LIM = 12'(NUM_HART);

  logic        acc, wr, inc, unused_addr;
  logic [15:0] word_addr;
  logic [11:0] msip_idx;
  logic [10:0] cmp_idx;
  logic        cmp_hi;
  logic        msip_hit, cmp_hit, ctrl_hit, presc_hit, mtimel_hit, mtimeh_hit, any_hit;
  logic [31:0] rdata;

  ctrl_t                ctrl_q, ctrl_d;
  logic [PSC_WIDTH-1:0] presc_q, presc_d;
  logic [MW-1:0]        mtime_q, mtime_d;

  logic [NUM_HART-1:0]  msip_vec;
  logic [MW-1:0]        cmp_arr [NUM_HART];

  assign acc         = apb.psel & apb.penable;
  assign wr          = acc & apb.pwrite;
  assign word_addr   = {apb.paddr[15:2], 2'b00};
  assign unused_addr = ^apb.paddr[1:0];
  assign msip_idx    = apb.paddr[13:2];
  assign cmp_idx     = apb.paddr[13:3];
  assign cmp_hi      = apb.paddr[2];

  assign msip_hit   = (word_addr[15:14] == MSIP_BASE[15:14]) && (msip_idx < HART_LIM);
  assign cmp_hit    = (word_addr[15:14] == MTIMECMP_BASE[15:14]) && ({1'b0, cmp_idx} < HART_LIM);
  assign ctrl_hit   = (word_addr == CTRL_OFS);
  assign presc_hit  = (word_addr == PRESC_OFS);
  assign mtimel_hit = (word_addr == MTIMEL_OFS);
  assign mtimeh_hit = (word_addr == MTIMEH_OFS);
  assign any_hit    = msip_hit | cmp_hit | ctrl_hit | presc_hit | mtimel_hit | mtimeh_hit;

  clint_tick_gen #(.PSC_WIDTH(PSC_WIDTH)) u_tick (
    .clk_i      (pclk),
    .rst_ni     (presetn),
    .rtc_clk_i  (rtc_clk_i),
    .en_i       (ctrl_q.en),
    .src_i      (ctrl_q.src),
    .presc_i    (presc_q),
    .presc_wr_i (wr && presc_hit),
    .inc_o      (inc)
  );

  // Global register next state; an mtime write replaces the increment.
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    mtime_d = inc ? mtime_q + 64'd1 : mtime_q;
    if (wr && ctrl_hit)   ctrl_d  = ctrl_t'(apb.pwdata[1:0]);
    if (wr && presc_hit)  presc_d = apb.pwdata[PSC_WIDTH-1:0];
    if (wr && mtimel_hit) mtime_d = {mtime_q[63:32], apb.pwdata};
    if (wr && mtimeh_hit) mtime_d = {apb.pwdata, mtime_q[31:0]};
  end

  // Global registers: CTRL resets enabled with the rtc source selected.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ctrl_q  <= '{src: 1'b0, en: 1'b1};
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  for (genvar h = 0; h < NUM_HART; h++) begin : g_hart
    logic          msip_q, msip_d, sel_msip, sel_cmp;
    logic [MW-1:0] cmp_q, cmp_d;

    assign sel_msip = wr && msip_hit && (msip_idx == 12'(h));
    assign sel_cmp  = wr && cmp_hit && (cmp_idx == 11'(h));

    // Per-hart next state: msip bit 0 and one mtimecmp half per write.
    always_comb begin
      msip_d = msip_q;
      cmp_d  = cmp_q;
      if (sel_msip) msip_d = apb.pwdata[0];
      if (sel_cmp) begin
        if (cmp_hi) cmp_d[63:32] = apb.pwdata;
        else        cmp_d[31:0]  = apb.pwdata;
      end
    end

    // Per-hart registers; mtimecmp resets to all-ones so no irq fires.
    always_ff @(posedge pclk) begin
      if (!presetn) begin
        msip_q <= 1'b0;
        cmp_q  <= '1;
      end else begin
        msip_q <= msip_d;
        cmp_q  <= cmp_d;
      end
    end

    assign msip_vec[h]  = msip_q;
    assign cmp_arr[h]   = cmp_q;
    assign tmr_irq_o[h] = (mtime_q >= cmp_q);
    assign sfr_irq_o[h] = msip_q;
  end

  // Read mux: pre-update register values, zero outside the access phase.
  always_comb begin
    rdata = '0;
    if (acc) begin
      for (int h = 0; h < NUM_HART; h++) begin
        if (msip_hit && (msip_idx == 12'(h))) rdata = {31'b0, msip_vec[h]};
        if (cmp_hit && (cmp_idx == 11'(h)))
          rdata = cmp_hi ? cmp_arr[h][63:32] : cmp_arr[h][31:0];
      end
      if (ctrl_hit)   rdata = {30'b0, ctrl_q};
      if (presc_hit)  rdata = 32'(presc_q);
      if (mtimel_hit) rdata = mtime_q[31:0];
      if (mtimeh_hit) rdata = mtime_q[63:32];
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pslverr = acc & ~any_hit;
  assign apb.pready  = 1'b1;
endmodule

// File: tb/tb_apb4_mclint.sv
// Bench for apb4_mclint: APB reads/writes queue their expected response,
// a negedge monitor pops and compares during each access phase.
module tb_apb4_mclint;
  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       rtc_clk = 1'b0;
  logic [3:0] tmr, sfr;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  apb4_mclint_if apb();

  apb4_mclint #(.NUM_HART(4), .PSC_WIDTH(16)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (apb),
    .rtc_clk_i (rtc_clk),
    .tmr_irq_o (tmr),
    .sfr_irq_o (sfr)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d, input logic err, input string tag);
    apb.paddr = a; apb.pwdata = d; apb.pwrite = 1'b1; apb.psel = 1'b1; apb.penable = 1'b0;
    tick(1);
    apb.penable = 1'b1;
    sb_q.push_back('{is_rd: 1'b0, data: 32'h0, err: err});
    tag_q.push_back(tag);
    tick(1);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [15:0] a, input logic [31:0] d, input logic err, input string tag);
    apb.paddr = a; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
    tick(1);
    apb.penable = 1'b1;
    sb_q.push_back('{is_rd: 1'b1, data: d, err: err});
    tag_q.push_back(tag);
    tick(1);
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  always @(negedge pclk) begin
    if (apb.psel && apb.penable) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        if (e.is_rd) chk({t, "_rdata"}, apb.prdata, e.data);
        chk({t, "_slverr"}, apb.pslverr, e.err);
      end
    end
  end

  initial begin
    int c0, ce, cw, cf;
    logic [31:0] frozen;
    apb.paddr = '0; apb.pwdata = '0; apb.pwrite = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;

    // reset state
    tick(3);
    chk("rst_tmr", tmr, 4'b0000);
    chk("rst_sfr", sfr, 4'b0000);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_pslverr", apb.pslverr, 1'b0);
    chk("rst_pready", apb.pready, 1'b1);
    presetn = 1'b1;
    tick(1);
    apb_rd(16'h4000, 32'hFFFF_FFFF, 1'b0, "cmp0_lo");
    apb_rd(16'h4004, 32'hFFFF_FFFF, 1'b0, "cmp0_hi");
    apb_rd(16'hBFF0, 32'h1, 1'b0, "ctrl_rst");
    apb_rd(16'hBFF4, 32'h0, 1'b0, "presc_rst");
    apb_rd(16'hBFF8, 32'h0, 1'b0, "mtimel_rst");

    // msip and unmapped accesses
    apb_wr(16'h0008, 32'h1, 1'b0, "msip2_wr");
    chk("sfr_msip2", sfr, 4'b0100);
    apb_wr(16'h0014, 32'h1, 1'b1, "msip5_wr");
    chk("sfr_after_msip5", sfr, 4'b0100);
    apb_rd(16'h0014, 32'h0, 1'b1, "msip5_rd");
    apb_rd(16'h0008, 32'h1, 1'b0, "msip2_rd");
    apb_rd(16'h2000, 32'h0, 1'b1, "unmapped_2000");
    apb_rd(16'h4020, 32'h0, 1'b1, "cmp4_rd");
    apb_wr(16'h0008, 32'h0, 1'b0, "msip2_clr");
    chk("sfr_cleared", sfr, 4'b0000);

    // pclk source with PRESC=3: mtime reaches 10 at 40 cycles
    apb_wr(16'h4008, 32'd10, 1'b0, "cmp1_lo_wr");
    apb_wr(16'h400C, 32'd0, 1'b0, "cmp1_hi_wr");
    apb_wr(16'hBFF4, 32'd3, 1'b0, "presc3_wr");
    apb_wr(16'hBFF0, 32'h3, 1'b0, "ctrl_src1");
    c0 = cyc;
    tick(39);
    chk("tmr_k39", tmr, 4'b0000);
    tick(1);
    chk("tmr_k40", tmr, 4'b0010);
    apb_rd(16'hBFF8, 32'((cyc + 1 - c0) / 4), 1'b0, "mtime_psc");
    apb_wr(16'hBFF0, 32'h1, 1'b0, "ctrl_src0");
    apb_wr(16'hBFF8, 32'h0, 1'b0, "mtimel_zero");
    apb_wr(16'hBFF4, 32'h0, 1'b0, "presc0_wr");
    apb_wr(16'h400C, 32'hFFFF_FFFF, 1'b0, "cmp1_hi_ones");
    apb_wr(16'h4008, 32'hFFFF_FFFF, 1'b0, "cmp1_lo_ones");
    chk("tmr_cmp1_off", tmr, 4'b0000);

    // rtc source, period 8 pclk, PRESC=0
    apb_wr(16'h4000, 32'd1, 1'b0, "cmp0_lo_wr");
    apb_wr(16'h4004, 32'd0, 1'b0, "cmp0_hi_wr");
    chk("tmr_cmp0_pre", tmr, 4'b0000);
    for (int p = 0; p < 4; p++) begin
      rtc_clk = 1'b1;
      tick(2);
      if (p == 0) chk("rtc_edge2", tmr, 4'b0000);
      tick(1);
      if (p == 0) chk("rtc_edge3", tmr, 4'b0001);
      tick(1);
      rtc_clk = 1'b0;
      apb_rd(16'hBFF8, 32'(p + 1), 1'b0, "mtime_rtc");
      tick(2);
    end
    apb_wr(16'h4004, 32'hFFFF_FFFF, 1'b0, "cmp0_hi_ones");
    apb_wr(16'h4000, 32'hFFFF_FFFF, 1'b0, "cmp0_lo_ones");
    chk("tmr_cmp0_off", tmr, 4'b0000);

    // mtime wrap drops irq of hart 3 (mtimecmp=5)
    apb_wr(16'h4018, 32'd5, 1'b0, "cmp3_lo_wr");
    apb_wr(16'h401C, 32'd0, 1'b0, "cmp3_hi_wr");
    chk("tmr_cmp3_pre", tmr, 4'b0000);
    apb_wr(16'hBFF8, 32'hFFFF_FFFF, 1'b0, "mtimel_ones");
    chk("tmr_mtimel_ones", tmr, 4'b1000);
    apb_wr(16'hBFFC, 32'hFFFF_FFFF, 1'b0, "mtimeh_ones");
    chk("tmr_mtime_max", tmr, 4'b1111);
    apb_wr(16'hBFF0, 32'h3, 1'b0, "ctrl_src1_wrap");
    ce = cyc;
    chk("tmr_before_wrap", tmr, 4'b1111);
    tick(1);
    chk("tmr_after_wrap", tmr, 4'b0000);
    apb_rd(16'hBFFC, 32'h0, 1'b0, "mtimeh_wrap");
    apb_rd(16'hBFF8, 32'(cyc - ce), 1'b0, "mtimel_wrap");
    for (int i = 0; i < 4; i++) begin
      chk("tmr_cmp3_reach", tmr, ((cyc - ce - 1) >= 5) ? 4'b1000 : 4'b0000);
      tick(1);
    end

    // MTIME write collides with inc; then EN=0 freezes mtime
    apb_wr(16'hBFF8, 32'h100, 1'b0, "mtimel_collide");
    cw = cyc;
    apb_rd(16'hBFF8, 32'h100 + 32'(cyc + 1 - cw), 1'b0, "mtimel_no_carry");
    apb_rd(16'hBFFC, 32'h0, 1'b0, "mtimeh_collide");
    apb_wr(16'hBFF0, 32'h2, 1'b0, "ctrl_dis");
    cf = cyc;
    frozen = 32'h100 + 32'(cf - cw);
    apb_rd(16'hBFF8, frozen, 1'b0, "mtime_frozen0");
    tick(20);
    apb_rd(16'hBFF8, frozen, 1'b0, "mtime_frozen20");
    apb_rd(16'hBFF0, 32'h2, 1'b0, "ctrl_dis_rd");

    // reset mid-count
    apb_wr(16'hBFF0, 32'h3, 1'b0, "ctrl_reen");
    apb_wr(16'h0004, 32'h1, 1'b0, "msip1_wr");
    chk("sfr_msip1", sfr, 4'b0010);
    presetn = 1'b0;
    tick(1);
    chk("rst2_tmr", tmr, 4'b0000);
    chk("rst2_sfr", sfr, 4'b0000);
    presetn = 1'b1;
    apb_rd(16'hBFF8, 32'h0, 1'b0, "rst2_mtimel");
    apb_rd(16'hBFF0, 32'h1, 1'b0, "rst2_ctrl");
    apb_rd(16'h4018, 32'hFFFF_FFFF, 1'b0, "rst2_cmp3_lo");

    tick(2);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
